// File: rtl/tmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tmem_pkg                                               |
// | Description : Shared types and constants for the tagged memory port. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package tmem_pkg;

    // Port controller states
    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        LOCK_RD = 2'd2,
        LOCK_WR = 2'd3
    } tmem_state_t;

    localparam int          DATA_W    = 64;
    localparam int          TAG_W     = 8;
    localparam int          WORD_W    = DATA_W + TAG_W;
    localparam logic [7:0]  TAG_EMPTY = 8'h34;

endpackage : tmem_pkg
`default_nettype wire

// File: rtl/tmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tmem_array                                             |
// | Description : Single-port synchronous word array, data+tag per word, |
// |               registered read output with enable.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tmem_array
    import tmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WORD_W-1:0]     i_wdata,
    output logic [WORD_W-1:0]     o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] r_mem [0:c_DEPTH-1];
    logic [WORD_W-1:0] r_rdata;

    // Commit writes at the request edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Output register only updates on a read, so the result holds between reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : tmem_array
`default_nettype wire

// File: rtl/tmem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tmem_port                                              |
// | Description : Memory-side responder for the tagged CPU bus: address  |
// |               latch, atomic read-then-write lock, reset-time clear   |
// |               sweep and sticky protocol-error flag.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tmem_port
    import tmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 20,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           i_ad,
    input  logic [7:0]            i_tag,
    input  logic                  i_astb,
    input  logic                  i_atomic,
    input  logic                  i_rd,
    input  logic                  i_wr,
    output logic [63:0]           o_data,
    output logic [7:0]            o_tag,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic                  o_busy,
    output logic                  o_locked,
    output logic                  o_err
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR   = '1;
    localparam tmem_state_t           c_RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    tmem_state_t           r_state;
    tmem_state_t           w_next_state;
    logic                  w_err_set;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_err;
    logic                  r_locked;
    logic                  r_busy;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [ADDR_WIDTH-1:0] w_arr_addr;
    logic [WORD_W-1:0]     w_arr_wdata;
    logic [WORD_W-1:0]     w_arr_rdata;

    // A strobe in the same cycle as an access redirects that access (bypass)
    assign w_addr = i_astb ? i_ad[ADDR_WIDTH-1:0] : r_waddr;

    // Next-state and protocol-violation detection
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                if (i_rd && i_wr) begin
                    w_err_set = 1'b1;
                end
                if (i_astb && i_atomic) begin
                    if (i_wr) begin
                        // A write cannot be the first access of an atomic pair
                        w_err_set = 1'b1;
                    end else if (i_rd) begin
                        w_next_state = LOCK_WR;
                    end else begin
                        w_next_state = LOCK_RD;
                    end
                end
            end
            LOCK_RD: begin
                if (i_astb || i_wr) begin
                    w_err_set    = 1'b1;
                    w_next_state = IDLE;
                end else if (i_rd) begin
                    w_next_state = LOCK_WR;
                end
            end
            LOCK_WR: begin
                if (i_astb || i_rd) begin
                    w_err_set    = 1'b1;
                    w_next_state = IDLE;
                end else if (i_wr) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register plus registered status flags derived from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_RESET_STATE;
            r_busy   <= (c_RESET_STATE == CLEAR);
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= (w_next_state == CLEAR);
            r_locked <= (w_next_state == LOCK_RD) || (w_next_state == LOCK_WR);
            r_err    <= r_err | w_err_set;
        end
    end

    // Clear-sweep word counter; it wraps back to zero as the sweep ends
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Address latch; held until the next strobe, ignored during the sweep
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_waddr <= '0;
        end else if ((r_state != CLEAR) && i_astb) begin
            r_waddr <= i_ad[ADDR_WIDTH-1:0];
        end
    end

    // Array port mux: sweep owns the port while clearing, the bus otherwise
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_re    = 1'b0;
        w_arr_addr  = w_addr;
        w_arr_wdata = {i_ad, i_tag};
        if (r_state == CLEAR) begin
            w_arr_we    = 1'b1;
            w_arr_addr  = r_clr_cnt;
            w_arr_wdata = {{DATA_W{1'b0}}, TAG_EMPTY};
        end else begin
            w_arr_we = i_wr;
            // A read colliding with a write is dropped
            w_arr_re = i_rd && !i_wr;
        end
    end

    tmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign o_data   = w_arr_rdata[TAG_W +: DATA_W];
    assign o_tag    = w_arr_rdata[TAG_W-1:0];
    assign o_waddr  = r_waddr;
    assign o_busy   = r_busy;
    assign o_locked = r_locked;
    assign o_err    = r_err;

endmodule : tmem_port
`default_nettype wire

// File: tb/tb_tmem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tmem_port                                           |
// | Description : Directed scoreboard bench for tmem_port (4-bit addr).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_tmem_port;

    localparam int AW = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   ad;
    logic [7:0]    tag;
    logic          astb;
    logic          atomic;
    logic          rd;
    logic          wr;
    logic [63:0]   o_data;
    logic [7:0]    o_tag;
    logic [AW-1:0] o_waddr;
    logic          o_busy;
    logic          o_locked;
    logic          o_err;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic rd_seen = 1'b0;

    tmem_port #(
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_ad     (ad),
        .i_tag    (tag),
        .i_astb   (astb),
        .i_atomic (atomic),
        .i_rd     (rd),
        .i_wr     (wr),
        .o_data   (o_data),
        .o_tag    (o_tag),
        .o_waddr  (o_waddr),
        .o_busy   (o_busy),
        .o_locked (o_locked),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    // Mark the cycle after an accepted read so the monitor knows data is due
    always @(posedge clk) rd_seen <= reset && rd && !wr;

    // Monitor: pop the expected read result and compare once it is visible
    always @(negedge clk) begin
        if (rd_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got data=%h tag=%h, required no read", o_data, o_tag);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_data !== mon_e.d || o_tag !== mon_e.t) begin
                    bad++;
                    $display("FAIL rd_data: got data=%h tag=%h, required data=%h tag=%h",
                             o_data, o_tag, mon_e.d, mon_e.t);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [7:0] t);
        exp_t e;
        e.d = d;
        e.t = t;
        exp_q.push_back(e);
    endtask

    // One bus cycle: drive, pass the edge, then return inputs to idle
    task automatic op(input logic a_astb, input logic a_atom, input logic a_rd,
                      input logic a_wr, input logic [63:0] a_ad, input logic [7:0] a_tag);
        astb   = a_astb;
        atomic = a_atom;
        rd     = a_rd;
        wr     = a_wr;
        ad     = a_ad;
        tag    = a_tag;
        @(posedge clk);
        #1;
        astb   = 1'b0;
        atomic = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        astb   = 1'b0;
        atomic = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ad     = '0;
        tag    = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Count edges until the sweep ends, bounded
    task automatic busy_len(input string name, input int req);
        int n = 0;
        while (o_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(n), 64'(req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and clear sweep length
        do_reset();
        chk("rst_data",   o_data,   64'h0);
        chk("rst_tag",    64'(o_tag),    64'h0);
        chk("rst_waddr",  64'(o_waddr),  64'h0);
        chk("rst_err",    64'(o_err),    64'h0);
        chk("rst_locked", 64'(o_locked), 64'h0);
        chk("rst_busy",   64'(o_busy),   64'h1);
        busy_len("clear_len", 16);

        // Every word cleared to zero data, empty tag
        for (int a = 0; a < 16; a++) begin
            push_exp(64'h0, 8'h34);
            op(1'b1, 1'b0, 1'b1, 1'b0, 64'(a), 8'h00);
        end

        // Write then read back at address 5
        op(1'b1, 1'b0, 1'b0, 1'b0, 64'd5, 8'h00);
        op(1'b0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF_01234567, 8'h02);
        push_exp(64'hDEADBEEF_01234567, 8'h02);
        op(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00);
        chk("waddr_5", 64'(o_waddr), 64'd5);

        // Same-cycle strobe+read at 3 with bit 63 set, previous address 5
        op(1'b1, 1'b0, 1'b0, 1'b0, 64'd3, 8'h00);
        op(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_AAAA_0000_0003, 8'h33);
        op(1'b1, 1'b0, 1'b0, 1'b0, 64'd5, 8'h00);
        push_exp(64'h0000_AAAA_0000_0003, 8'h33);
        op(1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0003, 8'h00);
        chk("waddr_bypass", 64'(o_waddr), 64'd3);

        // Read and write together: write wins, output holds, error set
        chk("err_before_rw", 64'(o_err), 64'h0);
        op(1'b0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_1234, 8'h44);
        chk("rw_data_hold", o_data, 64'h0000_AAAA_0000_0003);
        chk("rw_tag_hold",  64'(o_tag), 64'h33);
        chk("rw_err",       64'(o_err), 64'h1);
        push_exp(64'h0000_0000_0000_1234, 8'h44);
        op(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00);

        // Clean atomic sequence at address 7
        do_reset();
        busy_len("clear_len2", 16);
        op(1'b1, 1'b1, 1'b0, 1'b0, 64'd7, 8'h00);
        chk("atom_lock_strobe", 64'(o_locked), 64'h1);
        push_exp(64'h0, 8'h34);
        op(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00);
        chk("atom_lock_read", 64'(o_locked), 64'h1);
        op(1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 8'h05);
        chk("atom_unlock", 64'(o_locked), 64'h0);
        chk("atom_err",    64'(o_err),    64'h0);
        push_exp(64'h1, 8'h05);
        op(1'b1, 1'b0, 1'b1, 1'b0, 64'd7, 8'h00);

        // Violation: second strobe before the atomic read
        do_reset();
        busy_len("clear_len3", 16);
        op(1'b1, 1'b1, 1'b0, 1'b0, 64'd7, 8'h00);
        chk("v1_locked_open", 64'(o_locked), 64'h1);
        op(1'b1, 1'b0, 1'b0, 1'b0, 64'd2, 8'h00);
        chk("v1_err",    64'(o_err),    64'h1);
        chk("v1_locked", 64'(o_locked), 64'h0);
        push_exp(64'h0, 8'h34);
        op(1'b1, 1'b0, 1'b1, 1'b0, 64'd2, 8'h00);
        chk("v1_err_sticky", 64'(o_err), 64'h1);

        // Violation: atomic read (sharing the strobe cycle), then another read
        do_reset();
        busy_len("clear_len4", 16);
        push_exp(64'h0, 8'h34);
        op(1'b1, 1'b1, 1'b1, 1'b0, 64'd4, 8'h00);
        chk("v2_locked_open", 64'(o_locked), 64'h1);
        chk("v2_err_clean",   64'(o_err),    64'h0);
        push_exp(64'h0, 8'h34);
        op(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00);
        chk("v2_err",    64'(o_err),    64'h1);
        chk("v2_locked", 64'(o_locked), 64'h0);

        // Reset pulse mid-sweep restarts the full sweep
        do_reset();
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy", 64'(o_busy), 64'h1);
        do_reset();
        busy_len("mid_restart_len", 16);

        op(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        op(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tmem_port
`default_nettype wire
